// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep scheduler for the cordic_dds runtime config port.
// Steps a frequency word from f_start to f_stop with a programmable dwell per point.
module dds_sweep_ctrl #(
   parameter int FW_WIDTH    = 32,
   parameter int DWELL_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   abort,
   input  logic [1:0]             mode,
   input  logic [FW_WIDTH-1:0]    f_start,
   input  logic [FW_WIDTH-1:0]    f_stop,
   input  logic [FW_WIDTH-1:0]    f_step,
   input  logic [DWELL_WIDTH-1:0] dwell,
   input  logic [FW_WIDTH-1:0]    phase_word,
   output logic                   cfg_vld,
   output logic [FW_WIDTH-1:0]    cfg_freq_word,
   output logic [FW_WIDTH-1:0]    cfg_phase_word,
   output logic                   busy,
   output logic                   done,
   output logic [15:0]            sweep_cnt,
   output logic [1:0]             dbg_state
);

   // cfg_vld is a one-cycle strobe with no ready: the DDS must accept the
   // word/phase pair in every cycle cfg_vld is high; both words hold otherwise.

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DWELL = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [FW_WIDTH-1:0]    start_q, stop_q, step_q, phase_q;
   logic [FW_WIDTH-1:0]    cur_q, cur_d;
   logic [1:0]             mode_q;
   logic [DWELL_WIDTH-1:0] dwell_q, cnt_q, cnt_d;
   logic                   dir_up_q, dir_up_d;
   logic [FW_WIDTH:0]      up_sum, down_lim;
   logic [FW_WIDTH-1:0]    up_next, down_next, phase_d;
   logic                   latch, degen, at_end;
   logic                   cfg_vld_d, done_d, busy_d, cnt_inc;

   assign latch     = (state_q == S_IDLE) && start && !abort;
   assign phase_d   = latch ? phase_word : phase_q;
   assign dbg_state = state_q;

   // Sums are one bit wider so a step near the top of the range clamps instead of wrapping.
   assign up_sum    = {1'b0, cur_q} + {1'b0, step_q};
   assign up_next   = (up_sum >= {1'b0, stop_q}) ? stop_q : up_sum[FW_WIDTH-1:0];
   assign down_lim  = {1'b0, start_q} + {1'b0, step_q};
   assign down_next = ({1'b0, cur_q} < down_lim) ? start_q : (cur_q - step_q);

   assign degen  = (step_q == '0) || (start_q >= stop_q);
   assign at_end = degen || (dir_up_q ? (cur_q == stop_q) : (cur_q == start_q));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_q <= '0;
         stop_q  <= '0;
         step_q  <= '0;
         phase_q <= '0;
         dwell_q <= '0;
         mode_q  <= 2'd0;
      end else if (latch) begin
         start_q <= f_start;
         stop_q  <= f_stop;
         step_q  <= f_step;
         phase_q <= phase_word;
         dwell_q <= dwell;
         mode_q  <= (mode == 2'd3) ? 2'd0 : mode;
      end
   end

   always_comb begin
      state_d   = state_q;
      cur_d     = cur_q;
      cnt_d     = cnt_q;
      dir_up_d  = dir_up_q;
      cfg_vld_d = 1'b0;
      done_d    = 1'b0;
      cnt_inc   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (latch) begin
               state_d  = S_ISSUE;
               cur_d    = f_start;
               dir_up_d = 1'b1;
            end
         end
         S_ISSUE: begin
            state_d = S_DWELL;
            cnt_d   = (dwell_q == '0) ? '0 : (dwell_q - DWELL_WIDTH'(1));
         end
         S_DWELL: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - DWELL_WIDTH'(1);
            end else if (at_end) begin
               cnt_inc = 1'b1;
               case (mode_q)
                  2'd1: begin
                     state_d = S_ISSUE;
                     cur_d   = start_q;
                  end
                  2'd2: begin
                     state_d = S_ISSUE;
                     if (degen) begin
                        cur_d = start_q;
                     end else begin
                        dir_up_d = !dir_up_q;
                        cur_d    = dir_up_q ? down_next : up_next;
                     end
                  end
                  default: begin
                     state_d = S_IDLE;
                     done_d  = 1'b1;
                  end
               endcase
            end else begin
               state_d = S_ISSUE;
               cur_d   = dir_up_q ? up_next : down_next;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Abort overrides whatever the sweep wanted to do this cycle.
      if (abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         cur_d   = cur_q;
         done_d  = 1'b0;
         cnt_inc = 1'b0;
      end

      cfg_vld_d = (state_d == S_ISSUE);
      busy_d    = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         cur_q          <= '0;
         cnt_q          <= '0;
         dir_up_q       <= 1'b1;
         cfg_vld        <= 1'b0;
         cfg_freq_word  <= '0;
         cfg_phase_word <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         sweep_cnt      <= 16'd0;
      end else begin
         state_q  <= state_d;
         cur_q    <= cur_d;
         cnt_q    <= cnt_d;
         dir_up_q <= dir_up_d;
         cfg_vld  <= cfg_vld_d;
         busy     <= busy_d;
         done     <= done_d;
         if (cfg_vld_d) begin
            cfg_freq_word  <= cur_d;
            cfg_phase_word <= phase_d;
         end
         if (cnt_inc) begin
            sweep_cnt <= sweep_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: single, clamp, triangle, sawtooth,
// abort/reset and degenerate sweeps, with an expected-word queue.
module tb_dds_sweep_ctrl;

   localparam int FW = 32;
   localparam int DW = 16;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          abort;
   logic [1:0]    mode;
   logic [FW-1:0] f_start, f_stop, f_step, phase_word;
   logic [DW-1:0] dwell;
   logic          cfg_vld;
   logic [FW-1:0] cfg_freq_word, cfg_phase_word;
   logic          busy, done;
   logic [15:0]   sweep_cnt;
   logic [1:0]    dbg_state;

   dds_sweep_ctrl #(.FW_WIDTH(FW), .DWELL_WIDTH(DW)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .abort          (abort),
      .mode           (mode),
      .f_start        (f_start),
      .f_stop         (f_stop),
      .f_step         (f_step),
      .dwell          (dwell),
      .phase_word     (phase_word),
      .cfg_vld        (cfg_vld),
      .cfg_freq_word  (cfg_freq_word),
      .cfg_phase_word (cfg_phase_word),
      .busy           (busy),
      .done           (done),
      .sweep_cnt      (sweep_cnt),
      .dbg_state      (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // scoreboard state
   logic [FW-1:0] exp_q[$];
   int            vld_cyc[$];
   int            vld_swc[$];
   int            busy_cnt;
   int            done_cnt;
   int            n_tests = 0;
   int            n_fail  = 0;
   int            t;
   int            dcyc;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // monitor: labels each sample with the cycle number used in the timing plan
   always @(negedge clk) begin
      if (rst_n) begin
         if (cfg_vld) begin
            vld_cyc.push_back(cyc + 1);
            vld_swc.push_back(int'(sweep_cnt));
            if (exp_q.size() == 0) check("extra_vld", cfg_vld, 1'b0);
            else check("freq_word", cfg_freq_word, exp_q.pop_front());
         end
         if (busy) busy_cnt++;
         if (done) done_cnt++;
      end
   end

   // driver tasks
   task automatic setup(input logic [1:0] m, input logic [FW-1:0] fs, input logic [FW-1:0] fp,
                        input logic [FW-1:0] st, input logic [DW-1:0] dw);
      mode = m; f_start = fs; f_stop = fp; f_step = st; dwell = dw;
      exp_q.delete(); vld_cyc.delete(); vld_swc.delete();
      busy_cnt = 0; done_cnt = 0;
   endtask

   task automatic pulse_start(output int ts);
      @(negedge clk); #1;
      start = 1'b1;
      ts = cyc + 1;
      @(negedge clk); #1;
      start = 1'b0;
   endtask

   task automatic pulse_abort();
      abort = 1'b1;
      @(negedge clk); #1;
      abort = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int dc);
      dc = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk); #1;
         if (done) begin
            dc = cyc + 1;
            check("busy_at_done", busy, 1'b0);
            break;
         end
      end
      if (dc < 0) check("done_timeout", done, 1'b1);
   endtask

   task automatic wait_vlds(input int n, input int budget);
      int i;
      for (i = 0; i < budget; i++) begin
         if (vld_cyc.size() >= n) break;
         @(negedge clk); #1;
      end
      if (vld_cyc.size() < n) check("vld_timeout", 64'(vld_cyc.size()), 64'(n));
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk); #1;
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; phase_word = '0;
      setup(2'd0, '0, '0, '0, '0);
      idle_cycles(3);
      check("rst_vld", cfg_vld, 1'b0);
      check("rst_freq", cfg_freq_word, '0);
      check("rst_phase", cfg_phase_word, '0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_swc", sweep_cnt, 16'd0);
      check("rst_state", dbg_state, 2'd0);
      @(negedge clk); rst_n = 1'b1;
      idle_cycles(2);

      // single up-sweep, dwell 3 -> period 4
      setup(2'd0, 32'd1000, 32'd1300, 32'd100, 16'd3);
      phase_word = 32'h1234_5678;
      exp_q.push_back(32'd1000); exp_q.push_back(32'd1100);
      exp_q.push_back(32'd1200); exp_q.push_back(32'd1300);
      pulse_start(t);
      phase_word = 32'hDEAD_BEEF;
      f_stop = 32'd5000;
      wait_done(100, dcyc);
      check("s_done_cyc", 64'(dcyc), 64'(t + 17));
      check("s_nvld", 64'(vld_cyc.size()), 64'd4);
      if (vld_cyc.size() >= 4) begin
         check("s_vld0", 64'(vld_cyc[0]), 64'(t + 1));
         check("s_vld1", 64'(vld_cyc[1]), 64'(t + 5));
         check("s_vld3", 64'(vld_cyc[3]), 64'(t + 13));
      end
      check("s_phase", cfg_phase_word, 32'h1234_5678);
      check("s_swc", sweep_cnt, 16'd1);
      idle_cycles(3);
      check("s_done_pulse", 64'(done_cnt), 64'd1);
      check("s_busy_cycles", 64'(busy_cnt), 64'd16);
      check("s_hold_freq", cfg_freq_word, 32'd1300);

      // clamp near top of range, dwell 0 -> period 2
      setup(2'd0, 32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h80, 16'd0);
      exp_q.push_back(32'hFFFF_FF00); exp_q.push_back(32'hFFFF_FF80);
      exp_q.push_back(32'hFFFF_FFFF);
      pulse_start(t);
      wait_done(50, dcyc);
      check("c_done_cyc", 64'(dcyc), 64'(t + 7));
      check("c_nvld", 64'(vld_cyc.size()), 64'd3);
      if (vld_cyc.size() >= 3) check("c_vld2", 64'(vld_cyc[2]), 64'(t + 5));
      check("c_swc", sweep_cnt, 16'd2);
      check("c_exp_left", 64'(exp_q.size()), 64'd0);

      // triangle, dwell 1 -> period 2
      setup(2'd2, 32'd0, 32'd300, 32'd100, 16'd1);
      exp_q.push_back(32'd0);   exp_q.push_back(32'd100); exp_q.push_back(32'd200);
      exp_q.push_back(32'd300); exp_q.push_back(32'd200); exp_q.push_back(32'd100);
      exp_q.push_back(32'd0);   exp_q.push_back(32'd100);
      pulse_start(t);
      wait_vlds(8, 60);
      pulse_abort();
      check("t_abort_busy", busy, 1'b0);
      check("t_abort_state", dbg_state, 2'd0);
      if (vld_cyc.size() >= 8) begin
         check("t_span", 64'(vld_cyc[7] - vld_cyc[0]), 64'd14);
         check("t_swc_top", 64'(vld_swc[3]), 64'd2);
         check("t_swc_down", 64'(vld_swc[4]), 64'd3);
         check("t_swc_bot", 64'(vld_swc[6]), 64'd3);
         check("t_swc_up", 64'(vld_swc[7]), 64'd4);
      end
      idle_cycles(5);
      check("t_nvld", 64'(vld_cyc.size()), 64'd8);
      check("t_no_done", 64'(done_cnt), 64'd0);

      // sawtooth, dwell 2 -> period 3; start while busy is ignored
      setup(2'd1, 32'd10, 32'd25, 32'd10, 16'd2);
      exp_q.push_back(32'd10); exp_q.push_back(32'd20); exp_q.push_back(32'd25);
      exp_q.push_back(32'd10); exp_q.push_back(32'd20); exp_q.push_back(32'd25);
      exp_q.push_back(32'd10);
      pulse_start(t);
      f_start = 32'd777; mode = 2'd0;
      start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
      wait_vlds(7, 60);
      pulse_abort();
      if (vld_cyc.size() >= 7) begin
         check("w_period", 64'(vld_cyc[1] - vld_cyc[0]), 64'd3);
         check("w_swc_25", 64'(vld_swc[2]), 64'd4);
         check("w_swc_ret1", 64'(vld_swc[3]), 64'd5);
         check("w_swc_ret2", 64'(vld_swc[6]), 64'd6);
      end
      idle_cycles(4);
      check("w_nvld", 64'(vld_cyc.size()), 64'd7);

      // abort during dwell of second point
      setup(2'd0, 32'd1000, 32'd1300, 32'd100, 16'd3);
      exp_q.push_back(32'd1000); exp_q.push_back(32'd1100);
      pulse_start(t);
      wait_vlds(2, 30);
      idle_cycles(1);
      pulse_abort();
      check("a_busy", busy, 1'b0);
      idle_cycles(20);
      check("a_nvld", 64'(vld_cyc.size()), 64'd2);
      check("a_no_done", 64'(done_cnt), 64'd0);
      check("a_hold_freq", cfg_freq_word, 32'd1100);
      check("a_swc", sweep_cnt, 16'd6);

      // asynchronous reset mid-sweep
      setup(2'd0, 32'd1000, 32'd1300, 32'd100, 16'd3);
      exp_q.push_back(32'd1000); exp_q.push_back(32'd1100);
      pulse_start(t);
      wait_vlds(2, 30);
      idle_cycles(1);
      #2 rst_n = 1'b0;
      #1;
      check("r_freq", cfg_freq_word, '0);
      check("r_phase", cfg_phase_word, '0);
      check("r_busy", busy, 1'b0);
      check("r_swc", sweep_cnt, 16'd0);
      check("r_state", dbg_state, 2'd0);
      @(negedge clk); rst_n = 1'b1;
      idle_cycles(2);

      // degenerate step=0: single point then done
      setup(2'd0, 32'd500, 32'd1300, 32'd0, 16'd2);
      exp_q.push_back(32'd500);
      pulse_start(t);
      wait_done(40, dcyc);
      check("d_done_cyc", 64'(dcyc), 64'(t + 4));
      check("d_nvld", 64'(vld_cyc.size()), 64'd1);
      check("d_swc", sweep_cnt, 16'd1);

      // start and abort together in idle: nothing happens
      @(negedge clk); #1;
      start = 1'b1; abort = 1'b1;
      @(negedge clk); #1;
      start = 1'b0; abort = 1'b0;
      check("sa_state", dbg_state, 2'd0);
      check("sa_busy", busy, 1'b0);
      idle_cycles(10);
      check("sa_nvld", 64'(vld_cyc.size()), 64'd1);
      check("sa_done", 64'(done_cnt), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frequency-sweep scheduler that drives the runtime configuration port (`cfg_vld` / `cfg_freq_word` / `cfg_phase_word`) of `cordic_dds`. It steps the DDS frequency word from a start value to a stop value, holding each point for a programmable dwell time. Three sweep modes are supported: single, repeating sawtooth, and triangle. It sits between a register/host interface and the DDS core, in the same clock domain as the DDS.

## Interface
- `FW_WIDTH`, 32, width of frequency/phase words (matches the DDS accumulator).
- `DWELL_WIDTH`, 16, width of the dwell counter.
- `clk`  in  1  DDS clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request; latches all settings and begins a sweep; ignored while `busy`.
- `abort`  in  1  stops the sweep; returns to idle next cycle.
- `mode`  in  2  0 = single up-sweep, 1 = repeating sawtooth, 2 = triangle (up/down), 3 = treated as 0.
- `f_start`, `f_stop`, `f_step`  in  FW_WIDTH each  unsigned sweep bounds and increment.
- `dwell`  in  DWELL_WIDTH  cycles per point; 0 is treated as 1.
- `phase_word`  in  FW_WIDTH  phase offset sent with every point.
- `cfg_vld`  out  1  one-cycle config strobe to the DDS.
- `cfg_freq_word`  out  FW_WIDTH  current frequency word.
- `cfg_phase_word`  out  FW_WIDTH  latched `phase_word`.
- `busy`  out  1  high from the first `cfg_vld` until `done`/abort.
- `done`  out  1  one-cycle pulse at the end of a mode-0 sweep.
- `sweep_cnt`  out  16  completed-sweep counter; wraps at 0xFFFF→0.

## Operation
- **Reset values:** every output is 0, the FSM is in IDLE, and direction is up.
- **States:** IDLE, ISSUE, DWELL.
- **IDLE:**
  - If `start`=1 and `abort`=0: latch inputs into shadow registers, set `cur`=f_start, set direction up, go to ISSUE.
  - Later input changes have no effect until the next `start`.
- **ISSUE** (one cycle):
  - `cfg_vld`=1, `cfg_freq_word`=`cur`, `cfg_phase_word`=shadow phase.
  - Load dwell counter with max(dwell,1)−1, go to DWELL.
- **DWELL:**
  - Counter decrements each cycle. When it reaches 0, compute the next point and go to ISSUE (or IDLE when the sweep is done).
  - Total spacing between consecutive `cfg_vld` pulses is therefore max(dwell,1)+1 cycles.
- **Next point, up:** if `cur`+`f_step` ≥ `f_stop` (compare in FW_WIDTH+1 bits, so there is no wrap), next = `f_stop`; otherwise next = `cur`+`f_step`. The last point is always exactly `f_stop`.
- **Next point, down** (mode 2 only): if `cur` < `f_start`+`f_step` (FW_WIDTH+1 bits), next = `f_start`; otherwise next = `cur`−`f_step`.
- **Endpoint reached** (dwell of a point equal to `f_stop` while up, or `f_start` while down, expires):
  - Mode 0: go to IDLE, `done`=1 for one cycle, `busy`=0 in that same cycle, `sweep_cnt`+1.
  - Mode 1: next = `f_start`, `sweep_cnt`+1, continue.
  - Mode 2: flip direction, `sweep_cnt`+1, and take the next point in the new direction.
- **Degenerate settings** (`f_step`=0 or `f_start` ≥ `f_stop`): the point list is {`f_start`}, treated as an endpoint every dwell.
  - Mode 0 issues it once, then `done`.
  - Modes 1 and 2 reissue it every period, and `sweep_cnt` increments each period.
- **abort:**
  - From any non-IDLE state, go to IDLE the next cycle.
  - No further `cfg_vld`, no `done`, `busy` low from the next cycle.
  - `cfg_freq_word`/`cfg_phase_word` hold their last values.
  - `abort` and `start` in the same IDLE cycle: abort wins and the FSM stays in IDLE.
- **Holding behaviour:**
  - `cfg_freq_word`/`cfg_phase_word` change only in ISSUE cycles and hold otherwise.
  - `sweep_cnt` is cleared only by reset, never by `start`.
- **Reset mid-sweep:** outputs go to their reset values immediately (asynchronous); no `done` is produced.

## Timing
- All outputs are registered.
- `start` sampled at edge t → `cfg_vld` high during cycle t+1 with `f_start`; `busy` rises in t+1.
- Period between `cfg_vld` pulses: P = max(dwell,1)+1 cycles.
- Mode 0 with N points: `cfg_vld` at t+1, t+1+P, …, t+1+(N−1)P; `done` at t+1+(N−1)P+P−1+1 = t+1+NP−… expressed simply: `done` occurs P cycles after the last `cfg_vld`.
- `abort` sampled at edge a → state is IDLE and `busy`=0 in cycle a+1.
- `sweep_cnt` updates in the same cycle as `done` (mode 0), or in the ISSUE cycle of the post-endpoint point (modes 1 and 2).

## Test plan
- **Single sweep:** mode 0, start=1000, stop=1300, step=100, dwell=3, `start` at t → `cfg_vld` at t+1, t+5, t+9, t+13 with words 1000, 1100, 1200, 1300; `done` at t+17; `busy` 1 over t+1..t+16; `sweep_cnt`=1.
- **Clamp and no wrap:** mode 0, start=0xFFFFFF00, stop=0xFFFFFFFF, step=0x80, dwell=0 → words FFFFFF00, FFFFFF80, FFFFFFFF on every other cycle; then `done`; no wrap to 0.
- **Triangle:** mode 2, start=0, stop=300, step=100, dwell=1 → words 0,100,200,300,200,100,0,100…; `sweep_cnt` increments on the ISSUE of the 200 (downward) and of the second 100 (upward).
- **Sawtooth:** mode 1, start=10, stop=25, step=10 → 10, 20, 25, 10, 20, 25…; `sweep_cnt` increments on each return to 10; `start` pulses while `busy` are ignored.
- **Abort and reset:** abort during DWELL of the second point → no further `cfg_vld`, no `done`, `cfg_freq_word` holds 1100; then `rst_n` low mid-sweep → all outputs 0 asynchronously, `sweep_cnt`=0.
- **Degenerate:** mode 0 with step=0, start=500 → exactly one `cfg_vld` (500), then `done`; same-cycle `start`+`abort` in IDLE → nothing issued.
